// File: rtl/capture_sequencer_if.sv
// Bus between the capture sequencer and its command decoder, trigger unit,
// rate divider and sample RAM. The sequencer takes the slave side.
interface capture_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic              Arm;
    logic              Abort;
    logic              TrigEN;
    logic [ADDR_W-1:0] PreCount;
    logic              SampleEn;
    logic              TrigHit;
    logic              RdStart;
    logic              RdNext;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [ADDR_W-1:0] RdAddr;
    logic [ADDR_W-1:0] TrigAddr;
    logic              RdLast;
    logic              Busy;
    logic              Done;
    logic [2:0]        State;

    // Controllers drive the pulses and levels; the sequencer answers with RAM
    // addresses and status. Pulses (Arm, Abort, RdStart, RdNext) act on the
    // single rising edge of CLK on which they are high.
    modport master (
        output Arm, Abort, TrigEN, PreCount, SampleEn, TrigHit, RdStart, RdNext,
        input  WrEn, WrAddr, RdAddr, TrigAddr, RdLast, Busy, Done, State
    );

    modport slave (
        input  Arm, Abort, TrigEN, PreCount, SampleEn, TrigHit, RdStart, RdNext,
        output WrEn, WrAddr, RdAddr, TrigAddr, RdLast, Busy, Done, State
    );
endinterface

// File: rtl/capture_sequencer.sv
// Sequences one logic-analyzer capture into a circular sample RAM: arm,
// pre-trigger fill, trigger wait, post-trigger fill, done and readout.
module capture_sequencer #(
    parameter int ADDR_W = 10
) (
    input logic                CLK,
    input logic                CLR,
    capture_sequencer_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST = '1;  // DEPTH-1

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_READ = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;

    logic              wr_en;
    logic              rd_last;
    logic              arm_go;
    logic              trig_go;
    logic              rd_go;
    logic [ADDR_W-1:0] pre_cnt_inc;
    logic [ADDR_W-1:0] post_init;
    logic [ADDR_W-1:0] start_addr;

    // An ADDR_W-bit PreCount can never exceed DEPTH-1, so the clamp is implicit.
    assign pre_cnt_inc = pre_cnt_q + 1'b1;
    assign post_init   = LAST - pre_q;
    assign start_addr  = trig_addr_q - pre_q;

    assign wr_en   = bus.SampleEn && !bus.Abort &&
                     (state_q == S_PRE || state_q == S_WAIT || state_q == S_POST);
    assign rd_last = (state_q == S_READ) && (rd_cnt_q == LAST);
    assign arm_go  = !bus.Abort && bus.Arm && (state_q == S_IDLE || state_q == S_DONE);
    assign trig_go = wr_en && (state_q == S_WAIT) && bus.TrigHit && bus.TrigEN;
    // A new capture takes precedence over a readout request in DONE.
    assign rd_go   = !bus.Abort && !arm_go && bus.RdStart &&
                     (state_q == S_DONE || state_q == S_READ);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q     <= S_IDLE;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            trig_addr_q <= '0;
            pre_q       <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            rd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            trig_addr_q <= trig_addr_d;
            pre_q       <= pre_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.Abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (bus.Arm) state_d = (bus.PreCount != '0) ? S_PRE : S_WAIT;
                S_PRE:  if (wr_en && pre_cnt_inc == pre_q) state_d = S_WAIT;
                S_WAIT: if (trig_go) state_d = (post_init != '0) ? S_POST : S_DONE;
                S_POST: if (wr_en && post_cnt_q == ADDR_W'(1)) state_d = S_DONE;
                S_DONE: begin
                    if (bus.Arm)          state_d = (bus.PreCount != '0) ? S_PRE : S_WAIT;
                    else if (bus.RdStart) state_d = S_READ;
                end
                S_READ: if (!bus.RdStart && bus.RdNext && rd_last) state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_addr_d   = wr_en ? wr_addr_q + 1'b1 : wr_addr_q;
        rd_addr_d   = rd_addr_q;
        trig_addr_d = trig_addr_q;
        pre_d       = pre_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        rd_cnt_d    = rd_cnt_q;

        if (arm_go) begin
            pre_d     = bus.PreCount;
            wr_addr_d = '0;
            pre_cnt_d = '0;
        end
        if (wr_en && state_q == S_PRE) pre_cnt_d = pre_cnt_inc;
        if (trig_go) begin
            trig_addr_d = wr_addr_q;
            post_cnt_d  = post_init;
        end
        if (wr_en && state_q == S_POST) post_cnt_d = post_cnt_q - 1'b1;

        if (rd_go) begin
            rd_addr_d = start_addr;
            rd_cnt_d  = '0;
        end else if (!bus.Abort && bus.RdNext && state_q == S_READ) begin
            rd_addr_d = rd_addr_q + 1'b1;
            rd_cnt_d  = rd_cnt_q + 1'b1;
        end
    end

    always_comb begin
        bus.WrEn     = wr_en;
        bus.WrAddr   = wr_addr_q;
        bus.RdAddr   = rd_addr_q;
        bus.TrigAddr = trig_addr_q;
        bus.RdLast   = rd_last;
        bus.Busy     = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
        bus.Done     = (state_q == S_DONE) || (state_q == S_READ);
        bus.State    = state_q;
    end
endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer at ADDR_W=4 (DEPTH=16) with
// hand-computed expectations and an expected-write-address queue.
module tb_capture_sequencer;
    localparam int AW = 4;

    logic clk;
    logic clr;
    int   checks;
    int   failures;
    logic [AW-1:0] exp_q[$];

    capture_sequencer_if #(.ADDR_W(AW)) bus ();

    capture_sequencer #(.ADDR_W(AW)) dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_range(input int start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(AW'((start + i) % 16));
    endtask

    task automatic arm(input logic [AW-1:0] pc);
        bus.PreCount = pc;
        bus.Arm      = 1'b1;
        tick();
        bus.Arm      = 1'b0;
    endtask

    // One sample strobe; WrEn and the write address are checked before the edge.
    task automatic write_sample(input logic hit, input logic ten);
        bus.SampleEn = 1'b1;
        bus.TrigHit  = hit;
        bus.TrigEN   = ten;
        #1;
        chk("wr_en", bus.WrEn, 1);
        if (exp_q.size() > 0) chk("wr_addr", bus.WrAddr, exp_q.pop_front());
        else chk("exp_q_underflow", 1, 0);
        tick();
        bus.SampleEn = 1'b0;
        bus.TrigHit  = 1'b0;
    endtask

    task automatic gap_cycle(input logic [AW-1:0] hold_addr);
        bus.SampleEn = 1'b0;
        #1;
        chk("gap_wr_en", bus.WrEn, 0);
        chk("gap_wr_addr", bus.WrAddr, hold_addr);
        tick();
    endtask

    task automatic pulse_rd_start();
        bus.RdStart = 1'b1;
        tick();
        bus.RdStart = 1'b0;
    endtask

    task automatic pulse_rd_next();
        bus.RdNext = 1'b1;
        tick();
        bus.RdNext = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.Abort = 1'b1;
        tick();
        bus.Abort = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clr          = 1'b0;
        bus.Arm      = 1'b0;
        bus.Abort    = 1'b0;
        bus.TrigEN   = 1'b0;
        bus.PreCount = '0;
        bus.SampleEn = 1'b1;
        bus.TrigHit  = 1'b0;
        bus.RdStart  = 1'b0;
        bus.RdNext   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_state", bus.State, 0);
        chk("rst_wr_addr", bus.WrAddr, 0);
        chk("rst_rd_addr", bus.RdAddr, 0);
        chk("rst_trig_addr", bus.TrigAddr, 0);
        chk("rst_rd_last", bus.RdLast, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_wr_en", bus.WrEn, 0);
        bus.SampleEn = 1'b0;
        clr = 1'b1;
        tick();
        chk("idle_wr_en", bus.WrEn, 0);

        // Case 1: PreCount=4, trigger on the 7th write
        arm(4);
        chk("c1_state_pre", bus.State, 1);
        chk("c1_busy", bus.Busy, 1);
        push_range(0, 18);
        for (int i = 0; i < 18; i++) begin
            write_sample(i == 6, 1'b1);
            if (i == 3) chk("c1_state_wait", bus.State, 2);
            if (i == 6) begin
                chk("c1_trig_addr", bus.TrigAddr, 6);
                chk("c1_state_post", bus.State, 3);
            end
            if (i == 16) chk("c1_still_post", bus.State, 3);
        end
        chk("c1_state_done", bus.State, 4);
        chk("c1_busy_done", bus.Busy, 0);
        chk("c1_done", bus.Done, 1);
        chk("c1_wr_addr_end", bus.WrAddr, 2);

        // RdNext outside READ is ignored
        pulse_rd_next();
        chk("rdnext_in_done_state", bus.State, 4);
        chk("rdnext_in_done_addr", bus.RdAddr, 0);

        // Case 2: readout starting at StartAddr=2
        pulse_rd_start();
        chk("c2_state_read", bus.State, 5);
        chk("c2_start_addr", bus.RdAddr, 2);
        chk("c2_rd_last0", bus.RdLast, 0);
        chk("c2_done_read", bus.Done, 1);
        for (int k = 1; k <= 15; k++) begin
            pulse_rd_next();
            chk("c2_rd_addr", bus.RdAddr, (2 + k) % 16);
            chk("c2_rd_last", bus.RdLast, (k == 15) ? 1 : 0);
        end
        chk("c2_last_addr", bus.RdAddr, 1);
        pulse_rd_next();
        chk("c2_back_done", bus.State, 4);
        chk("c2_rd_last_clr", bus.RdLast, 0);
        chk("c2_done_again", bus.Done, 1);

        // RdStart in READ restarts; Arm in READ ignored; Abort from READ
        pulse_rd_start();
        pulse_rd_next();
        pulse_rd_next();
        pulse_rd_next();
        chk("restart_pre", bus.RdAddr, 5);
        pulse_rd_start();
        chk("restart_addr", bus.RdAddr, 2);
        arm(3);
        chk("arm_in_read", bus.State, 5);
        pulse_abort();
        chk("abort_read_state", bus.State, 0);
        chk("abort_read_done", bus.Done, 0);
        chk("abort_trig_held", bus.TrigAddr, 6);

        // Case 3: hits in PRE and with TrigEN low are ignored
        arm(2);
        push_range(0, 2 + 21 + 1 + 13);
        write_sample(1'b1, 1'b1);
        chk("c3_pre_hit_state", bus.State, 1);
        write_sample(1'b1, 1'b1);
        chk("c3_wait", bus.State, 2);
        chk("c3_trig_unchanged", bus.TrigAddr, 6);
        for (int i = 0; i < 21; i++) write_sample(1'b1, 1'b0);
        chk("c3_still_wait", bus.State, 2);
        chk("c3_wrapped_addr", bus.WrAddr, 7);
        chk("c3_trig_held", bus.TrigAddr, 6);
        write_sample(1'b1, 1'b1);
        chk("c3_trig_addr", bus.TrigAddr, 7);
        chk("c3_post", bus.State, 3);
        for (int i = 0; i < 13; i++) write_sample(1'b0, 1'b1);
        chk("c3_done", bus.State, 4);
        chk("c3_wr_addr_end", bus.WrAddr, 5);
        pulse_rd_start();
        chk("c3_start_addr", bus.RdAddr, 5);
        pulse_abort();

        // Case 4: PreCount=0, trigger on the first sample
        arm(0);
        chk("c4_wait", bus.State, 2);
        push_range(0, 16);
        write_sample(1'b1, 1'b1);
        chk("c4_trig_addr", bus.TrigAddr, 0);
        chk("c4_post", bus.State, 3);
        for (int i = 0; i < 15; i++) write_sample(1'b0, 1'b1);
        chk("c4_done", bus.State, 4);
        // Arm in DONE discards the data (checked in case 5), RdStart first
        pulse_rd_start();
        chk("c4_start_addr", bus.RdAddr, 0);
        pulse_abort();
        arm(0);
        push_range(0, 16);
        write_sample(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) write_sample(1'b0, 1'b1);
        chk("c4b_done", bus.State, 4);

        // Case 5: Arm from DONE, PreCount=15 with SampleEn gaps
        arm(15);
        chk("c5_pre", bus.State, 1);
        chk("c5_wr_addr0", bus.WrAddr, 0);
        push_range(0, 16);
        for (int i = 0; i < 15; i++) begin
            write_sample(1'b0, 1'b1);
            gap_cycle(AW'(i + 1));
        end
        chk("c5_wait", bus.State, 2);
        chk("c5_wr_addr", bus.WrAddr, 15);
        write_sample(1'b1, 1'b1);
        chk("c5_straight_done", bus.State, 4);
        chk("c5_trig_addr", bus.TrigAddr, 15);
        chk("c5_wr_addr_wrap", bus.WrAddr, 0);
        pulse_rd_start();
        chk("c5_start_addr", bus.RdAddr, 0);
        pulse_abort();

        // Case 6: Abort during POST
        arm(4);
        push_range(0, 7);
        for (int i = 0; i < 4; i++) write_sample(1'b0, 1'b1);
        write_sample(1'b1, 1'b1);
        write_sample(1'b0, 1'b1);
        write_sample(1'b0, 1'b1);
        chk("c6_post", bus.State, 3);
        bus.SampleEn = 1'b1;
        bus.Abort    = 1'b1;
        #1;
        chk("c6_abort_wr_en", bus.WrEn, 0);
        tick();
        bus.Abort    = 1'b0;
        bus.SampleEn = 1'b0;
        chk("c6_abort_state", bus.State, 0);
        chk("c6_abort_done", bus.Done, 0);
        chk("c6_abort_busy", bus.Busy, 0);
        chk("c6_abort_wr_addr", bus.WrAddr, 7);
        chk("c6_abort_trig", bus.TrigAddr, 4);

        // Case 7: CLR low during WAIT
        arm(2);
        push_range(0, 3);
        for (int i = 0; i < 3; i++) write_sample(1'b0, 1'b0);
        chk("c7_wait", bus.State, 2);
        bus.SampleEn = 1'b1;
        #2;
        clr = 1'b0;
        #1;
        chk("c7_clr_state", bus.State, 0);
        chk("c7_clr_wr_en", bus.WrEn, 0);
        chk("c7_clr_wr_addr", bus.WrAddr, 0);
        chk("c7_clr_trig", bus.TrigAddr, 0);
        chk("c7_clr_rd_addr", bus.RdAddr, 0);
        chk("c7_clr_done", bus.Done, 0);
        chk("c7_clr_busy", bus.Busy, 0);
        bus.SampleEn = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        arm(5);
        chk("c7_rearm_state", bus.State, 1);
        push_range(0, 1);
        write_sample(1'b0, 1'b1);
        chk("c7_rearm_wr_addr", bus.WrAddr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
